seq_scan_ctrl: RTL and testbench
================================

Name: seq_scan_ctrl

Overview:
Sequencer that owns the serial sequence detector (pattern 1-0-1-1-0, overlapping, Moore output `detected`) and lets it scan whole words.
- Accepts parallel words over a valid/ready handshake.
- Clears the detector, then shifts each word into it MSB-first, one bit per clock.
- Counts detector hits and reports the count and first-hit bit index over a second valid/ready handshake.
- Sits between a word-oriented producer and the bit-serial detector instance.

Parameters:
W, 8, word width in bits (W >= 2)
CW, $clog2(W+1), width of hit counter
IW, $clog2(W), width of bit index

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer word valid
in_ready  output  1  controller can accept a word
in_data  input  W  word to scan, bit W-1 sent first
det_stream  output  1  serial bit to detector `stream`
det_reset  output  1  drives detector `reset`
det_detected  input  1  detector `detected` (Moore, registered)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_hit  output  1  at least one match in word
out_count  output  CW  number of matches in word
out_first_idx  output  IW  bit index (0 = MSB/first sent) of final pattern bit of first match; 0 if none

Behaviour:
- Single clock domain; all state updates on posedge clk.
- reset has priority over everything. While reset is high:
  - det_reset=1;
  - next state IDLE;
  - in_ready=0 during the reset cycle;
  - out_valid=0, out_hit=0, out_count=0, out_first_idx=0, det_stream=0;
  - shift register, bit counter and accumulators are cleared.
- States (shared enum): IDLE, CLR, SHIFT, DRAIN, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into shift reg, zero bit counter, count and first-hit flag, then go to CLR.
- CLR: exactly one cycle, det_reset=1, det_stream=0, then go to SHIFT. The detector is in its start state at the first SHIFT cycle.
- SHIFT:
  - Lasts W cycles, i = 0..W-1.
  - det_stream = shift reg MSB; shift left each cycle; i increments.
  - After i=W-1, go to DRAIN.
- Hit sampling:
  - Because detector output lags its input by one cycle, det_detected sampled in SHIFT cycle i (i>=1) belongs to bit i-1.
  - det_detected sampled in DRAIN belongs to bit W-1.
  - It is ignored at SHIFT i=0.
  - On a sampled hit: count += 1, saturating at W. If no prior hit in this word: first_idx = bit index and hit flag = 1.
- DRAIN: one cycle, det_stream=0, performs the final sample, then go to REPORT.
- REPORT:
  - out_valid=1; out_* are registered and stable until the handshake.
  - in_ready=0.
  - On out_ready, go to IDLE.
  - out_valid may stay asserted indefinitely under backpressure.
- Outside CLR and reset, det_reset=0. Outside SHIFT, det_stream=0.
- Latency: word accepted at edge E0 gives CLR in cycle 1, SHIFT in cycles 2..W+1, DRAIN in cycle W+2, and out_valid high from cycle W+3.
- Minimum period is W+4 cycles per word, including the IDLE accept cycle.
- Reset mid-operation (any state) aborts the word; no partial result is ever presented.
- in_valid is ignored outside IDLE; in_data is only sampled on the accepting edge.

Decomposition:
- Package seq_scan_pkg holds:
  - the state enum typedef (IDLE, CLR, SHIFT, DRAIN, REPORT);
  - localparam for pattern length (5), used only by the bench model.
- One natural sub-module: seq_word_serializer, a W-bit load/shift register with bit counter that emits MSB-first and flags `last`.
- The accumulate and handshake logic stays in seq_scan_ctrl.
- The bench instantiates seq_scan_ctrl together with the existing detector.

Test Plan:
- W=8, in_data=8'b10110000, out_ready=1 -> out_valid in cycle 11 after accept; out_hit=1, out_count=1, out_first_idx=4.
- in_data=8'b10110110 (overlapping) -> out_count=2, out_first_idx=4, out_hit=1.
- in_data=8'h00, then 8'b01011000 back-to-back -> first result count=0, hit=0, idx=0; second count=1, idx=5. Check det_reset pulses exactly once before each word's SHIFT.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT -> out_* stable, in_ready=0, new in_valid ignored. Release -> result consumed, IDLE next cycle, in_ready=1.
- Assert reset in SHIFT at i=3 for 1 cycle -> det_reset=1 that cycle; next cycle IDLE, out_valid=0, in_ready=1. The next word (8'b10110000) still gives count=1, idx=4.
- in_data=8'hFF and 8'b10101010 -> count=0 both (no 10110 substring); confirms no false hits from stale detector state across words.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared types for the word-scanning sequencer around the serial 1-0-1-1-0 detector.
package seq_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    DRAIN,
    REPORT
  } scan_state_t;

  localparam int PATTERN_LEN = 5;

endpackage

// File: rtl/seq_word_serializer.sv
// W-bit load/shift register that emits a word MSB-first and counts the bits sent.
module seq_word_serializer #(
  parameter int W  = 8,
  parameter int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  data,
  output logic          bit_out,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic [W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= data;
      idx   <= '0;
    end else if (shift) begin
      shreg <= {shreg[W-2:0], 1'b0};
      idx   <= idx + 1'b1;
    end
  end

  assign bit_out = shreg[W-1];
  assign last    = (idx == IW'(W-1));

endmodule

// File: rtl/seq_scan_ctrl.sv
// Feeds parallel words bit-serially into the sequence detector and reports
// how many matches each word produced and where the first one ended.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W+1),
  parameter int IW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          det_stream,
  output logic          det_reset,
  input  logic          det_detected,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_hit,
  output logic [CW-1:0] out_count,
  output logic [IW-1:0] out_first_idx
);

  scan_state_t state, next_state;

  logic          ser_bit;
  logic [IW-1:0] ser_idx;
  logic          ser_last;
  logic          ser_shift;
  logic          accept;

  logic          hit;
  logic [CW-1:0] count;
  logic [IW-1:0] first_idx;
  logic          sample_en;
  logic [IW-1:0] sample_idx;

  seq_word_serializer #(
    .W  (W),
    .IW (IW)
  ) u_serializer (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .shift   (ser_shift),
    .data    (in_data),
    .bit_out (ser_bit),
    .idx     (ser_idx),
    .last    (ser_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    det_reset  = 1'b0;
    det_stream = 1'b0;
    ser_shift  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = CLR;
        end
      end
      CLR: begin
        det_reset  = 1'b1;
        next_state = SHIFT;
      end
      SHIFT: begin
        det_stream = ser_bit;
        ser_shift  = 1'b1;
        if (ser_last) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        next_state = REPORT;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (reset) begin
      next_state = IDLE;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      det_reset  = 1'b1;
      det_stream = 1'b0;
      ser_shift  = 1'b0;
    end
  end

  assign accept = in_valid && in_ready;

  // The detector output lags its input by a cycle, so each sample belongs to the previous bit.
  assign sample_en  = ((state == SHIFT) && (ser_idx != '0)) || (state == DRAIN);
  assign sample_idx = (state == DRAIN) ? IW'(W-1) : (ser_idx - 1'b1);

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      hit       <= 1'b0;
      count     <= '0;
      first_idx <= '0;
    end else if (sample_en && det_detected) begin
      if (count != CW'(W)) begin
        count <= count + 1'b1;
      end
      if (!hit) begin
        hit       <= 1'b1;
        first_idx <= sample_idx;
      end
    end
  end

  assign out_hit       = out_valid && hit;
  assign out_count     = out_valid ? count : '0;
  assign out_first_idx = out_valid ? first_idx : '0;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl driving a behavioural 1-0-1-1-0 Moore detector.
module tb_seq_scan_ctrl;
  import seq_scan_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       det_stream;
  logic       det_reset;
  logic       det_detected;
  logic       out_valid;
  logic       out_ready;
  logic       out_hit;
  logic [3:0] out_count;
  logic [2:0] out_first_idx;

  typedef struct {
    int hit;
    int count;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  int   total_checks = 0;
  int   passed_checks = 0;

  localparam logic [PATTERN_LEN-1:0] PATTERN = 5'b10110;
  logic [PATTERN_LEN-1:0] det_hist;

  seq_scan_ctrl #(.W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .det_stream    (det_stream),
    .det_reset     (det_reset),
    .det_detected  (det_detected),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_hit       (out_hit),
    .out_count     (out_count),
    .out_first_idx (out_first_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the existing detector: registered history, Moore match output.
  always @(posedge clk) begin
    if (det_reset) begin
      det_hist <= '0;
    end else begin
      det_hist <= {det_hist[PATTERN_LEN-2:0], det_stream};
    end
  end
  assign det_detected = (det_hist == PATTERN);

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_checks++;
    if (actual == expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("out_hit", int'(out_hit), e.hit);
        checkOutput("out_count", int'(out_count), e.count);
        checkOutput("out_first_idx", int'(out_first_idx), e.idx);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] word, input bit push,
                               input int e_hit, input int e_count, input int e_idx);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = word;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_ready", int'(in_ready), 1);
      in_valid = 1'b0;
    end else begin
      if (push) begin
        e.hit   = e_hit;
        e.count = e_count;
        e.idx   = e_idx;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic waitResult(output int lat, output int resets);
    lat    = 0;
    resets = 0;
    do begin
      @(negedge clk);
      lat++;
      if (det_reset) resets++;
    end while (!out_valid && lat < 100);
    if (!out_valid) checkOutput("result_valid", int'(out_valid), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int resets;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_det_reset", int'(det_reset), 1);
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_count", int'(out_count), 0);
    checkOutput("rst_det_stream", int'(det_stream), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", int'(in_ready), 1);

    // Single match, latency and a single detector clear
    applyStimulus(8'b10110000, 1'b1, 1, 1, 4);
    waitResult(lat, resets);
    checkOutput("latency", lat, 11);
    checkOutput("det_reset_pulses", resets, 1);

    // Overlapping second match
    applyStimulus(8'b10110110, 1'b1, 1, 2, 4);
    waitResult(lat, resets);
    checkOutput("det_reset_pulses2", resets, 1);

    // Back-to-back words
    applyStimulus(8'h00, 1'b1, 0, 0, 0);
    waitResult(lat, resets);
    checkOutput("det_reset_pulses3", resets, 1);
    applyStimulus(8'b01011000, 1'b1, 1, 1, 5);
    waitResult(lat, resets);
    checkOutput("det_reset_pulses4", resets, 1);
    checkOutput("latency_b2b", lat, 11);

    // Backpressure holds the result and blocks new words
    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(8'b10110000, 1'b1, 1, 1, 4);
    waitResult(lat, resets);
    @(posedge clk);
    #1 begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", int'(out_valid), 1);
      checkOutput("bp_out_count", int'(out_count), 1);
      checkOutput("bp_out_first_idx", int'(out_first_idx), 4);
      checkOutput("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1 begin
      out_ready = 1'b1;
      in_valid  = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_release_in_ready", int'(in_ready), 1);
    checkOutput("bp_release_out_valid", int'(out_valid), 0);

    // Reset during SHIFT i=3 aborts the word
    applyStimulus(8'b10110000, 1'b0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_det_reset", int'(det_reset), 1);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_in_ready", int'(in_ready), 1);
    checkOutput("abort_idle_out_valid", int'(out_valid), 0);
    applyStimulus(8'b10110000, 1'b1, 1, 1, 4);
    waitResult(lat, resets);

    // No-match words, including one that leaves the detector one bit from a hit
    applyStimulus(8'hFF, 1'b1, 0, 0, 0);
    waitResult(lat, resets);
    applyStimulus(8'b10101010, 1'b1, 0, 0, 0);
    waitResult(lat, resets);
    applyStimulus(8'b00001011, 1'b1, 0, 0, 0);
    waitResult(lat, resets);
    applyStimulus(8'b00000000, 1'b1, 0, 0, 0);
    waitResult(lat, resets);

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
